blowfish_mode_ctrl: RTL and testbench
=====================================

# blowfish_mode_ctrl

Parametrised block-cipher mode controller between a streaming data interface and a Blowfish cipher core (64- or 128-bit block). Adds ECB, CBC and CTR chaining, IV management and multi-block messages with valid/ready handshakes on both sides. Drives the core's Enable/Encrypt start interface and collects its ready pulse. Key scheduling stays inside the core.

## Interface
- BLOCK_W, 128: block width in bits (64 or 128); all data, IV and core buses.
- CTR_W, 32: width of the incrementing counter field (LSBs of the counter block); must satisfy 1 ≤ CTR_W ≤ BLOCK_W.
- Clk  in  1  clock.
- RstN  in  1  reset, asynchronous, active-low.
- mode  in  2  00 ECB, 01 CBC, 10 CTR, 11 reserved.
- encrypt  in  1  1 encrypt, 0 decrypt; ignored in CTR.
- iv_load  in  1  load iv into IV and chain registers; honoured only in IDLE.
- iv  in  BLOCK_W  initial vector / initial counter.
- in_valid, in_last  in  1 each  input beat valid; last block of message.
- in_data  in  BLOCK_W  input block.
- in_ready  out  1  high only in IDLE with no iv_load that cycle.
- out_valid, out_last  out  1 each  result valid; last block of message.
- out_data  out  BLOCK_W  result block.
- out_ready  in  1  downstream accept.
- core_start  out  1  single-cycle start pulse (core Enable).
- core_encrypt  out  1  core direction.
- core_din  out  BLOCK_W  core input block.
- core_dout  in  BLOCK_W  core output, valid when core_done.
- core_done  in  1  core ready pulse.
- mode_err  out  1  sticky: reserved mode was latched; cleared by iv_load.

## Operation
- States: IDLE → START → WAIT → OUT → IDLE.
- IDLE: in_ready=1. Accept when in_valid&in_ready: register in_data, in_last; on first beat of a message latch mode/encrypt (held until the last beat's output handshake). Go to START.
- START: core_start=1 for one cycle, core_din/core_encrypt driven from registers. Go to WAIT.
- WAIT: hold core_din/core_encrypt stable; on core_done capture result into out_data; go to OUT.
- OUT: out_valid=1 until out_ready; on handshake update chain, go to IDLE.
- ECB: core_din=in; out=core_dout.
- CBC enc: core_din=in⊕chain; out=core_dout; chain←core_dout.
- CBC dec: core_din=in; out=core_dout⊕chain; chain←in.
- CTR: core_encrypt=1; core_din=chain; out=in⊕core_dout; chain[CTR_W-1:0]←chain[CTR_W-1:0]+1 mod 2^CTR_W, upper bits unchanged (wrap-around, no carry out).
- Reserved mode: behaves as ECB; sets mode_err.
- After out handshake with out_last=1: chain←IV register (next message restarts from IV).
- iv_load in IDLE: IV and chain ← iv; same-cycle in_valid not accepted. iv_load outside IDLE ignored.
- core_done outside WAIT ignored.

## Timing
- Reset: state IDLE, out_valid=0, out_last=0, out_data=0, core_start=0, core_encrypt=0, core_din=0, mode_err=0, IV/chain=0; in_ready=1 one cycle after RstN release.
- Accept at edge T → core_start high in cycle T+1 → core_done at cycle D → out_valid high from D+1.
- Throughput: one block per core latency + 3 cycles with out_ready=1.
- out_data/out_last stable while out_valid && !out_ready.
- Reset asserted mid-operation: immediate return to reset values; pending core result discarded (core_done after reset ignored).

## Structure
- Package blowfish_mode_pkg: mode_e (ECB, CBC, CTR, RSVD), state_e, localparam check BLOCK_W∈{64,128}.
- No sub-modules; core instantiated by the parent (blowfish128_top for BLOCK_W=128).

## Test plan
Bench core model: dout = din ⊕ 128'h0F0F…0F (encrypt and decrypt identical), core_done 3 cycles after core_start; IV=128'h1.
- ECB enc, in=128'h1234_56ab_cd13_2536_1234_56ab_cd13_2536, last=1 → out=in⊕0F…0F, out_last=1, out_valid 5 cycles after accept.
- CBC enc two blocks 128'h0, 128'h0 → out0=128'h0F…0E, out1=out0⊕0F…0F = 128'h1; CBC dec of those → 128'h0, 128'h0.
- CTR, CTR_W=4, IV=128'hF, in=0 twice → core_din 128'hF then 128'h0 (wrap, upper bits unchanged); out=core_dout.
- Backpressure: out_ready low 10 cycles → out_data stable, in_ready=0, no second core_start.
- mode=11 → ECB result, mode_err=1 until iv_load.
- RstN low during WAIT → all outputs reset values; late core_done produces no out_valid.

Source files
------------

// File: rtl/blowfish_mode_pkg.sv
// Shared types and parameter sanity helpers for the Blowfish chaining-mode controller.
package blowfish_mode_pkg;

  typedef enum logic [1:0] {
    MODE_ECB  = 2'b00,
    MODE_CBC  = 2'b01,
    MODE_CTR  = 2'b10,
    MODE_RSVD = 2'b11
  } mode_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_START = 2'b01,
    ST_WAIT  = 2'b10,
    ST_OUT   = 2'b11
  } state_e;

  function automatic logic block_w_ok(input int w);
    return (w == 64) || (w == 128);
  endfunction

  function automatic logic ctr_w_ok(input int c, input int b);
    return (c >= 1) && (c <= b);
  endfunction

endpackage

// File: rtl/blowfish_mode_ctrl_if.sv
// Stream-side and core-side signals of the mode controller; slave is the controller's view.
interface blowfish_mode_ctrl_if #(
  parameter int BLOCK_W = 128
);

  logic [1:0]         mode;
  logic               encrypt;
  logic               iv_load;
  logic [BLOCK_W-1:0] iv;
  logic               in_valid;
  logic               in_last;
  logic [BLOCK_W-1:0] in_data;
  logic               in_ready;
  logic               out_valid;
  logic               out_last;
  logic [BLOCK_W-1:0] out_data;
  logic               out_ready;
  logic               core_start;
  logic               core_encrypt;
  logic [BLOCK_W-1:0] core_din;
  logic [BLOCK_W-1:0] core_dout;
  logic               core_done;
  logic               mode_err;

  modport master (
    output mode, encrypt, iv_load, iv, in_valid, in_last, in_data, out_ready,
           core_dout, core_done,
    input  in_ready, out_valid, out_last, out_data, core_start, core_encrypt,
           core_din, mode_err
  );

  modport slave (
    input  mode, encrypt, iv_load, iv, in_valid, in_last, in_data, out_ready,
           core_dout, core_done,
    output in_ready, out_valid, out_last, out_data, core_start, core_encrypt,
           core_din, mode_err
  );

endinterface

// File: rtl/blowfish_mode_ctrl.sv
// ECB/CBC/CTR chaining controller: one block in flight, drives the core start/done
// handshake and keeps IV and chain registers across multi-block messages.
module blowfish_mode_ctrl
  import blowfish_mode_pkg::*;
#(
  parameter int BLOCK_W = 128,
  parameter int CTR_W   = 32
) (
  input  logic               Clk,
  input  logic               RstN,
  blowfish_mode_ctrl_if.slave bus
);

  if (!block_w_ok(BLOCK_W)) begin : g_bad_block_w
    $error("blowfish_mode_ctrl: BLOCK_W must be 64 or 128");
  end
  if (!ctr_w_ok(CTR_W, BLOCK_W)) begin : g_bad_ctr_w
    $error("blowfish_mode_ctrl: CTR_W must be within 1..BLOCK_W");
  end

  state_e             state_r;
  mode_e              mode_r;
  logic               enc_r;
  logic               msg_active_r;
  logic               last_r;
  logic [BLOCK_W-1:0] data_r;
  logic [BLOCK_W-1:0] iv_r;
  logic [BLOCK_W-1:0] chain_r;
  logic               out_valid_r;
  logic               out_last_r;
  logic [BLOCK_W-1:0] out_data_r;
  logic               core_start_r;
  logic               core_encrypt_r;
  logic [BLOCK_W-1:0] core_din_r;
  logic               mode_err_r;

  mode_e              eff_mode_s;
  logic               eff_enc_s;
  logic               in_ready_s;
  logic [BLOCK_W-1:0] din_next_s;
  logic               enc_next_s;
  logic [BLOCK_W-1:0] result_s;
  logic [BLOCK_W-1:0] ctr_next_s;
  logic [BLOCK_W-1:0] chain_next_s;

  assign in_ready_s       = (state_r == ST_IDLE) && !bus.iv_load;
  assign bus.in_ready     = in_ready_s;
  assign bus.out_valid    = out_valid_r;
  assign bus.out_last     = out_last_r;
  assign bus.out_data     = out_data_r;
  assign bus.core_start   = core_start_r;
  assign bus.core_encrypt = core_encrypt_r;
  assign bus.core_din     = core_din_r;
  assign bus.mode_err     = mode_err_r;

  // Mode/direction come from the port on a message's first beat, from the latch afterwards.
  always_comb begin
    eff_mode_s = msg_active_r ? mode_r : mode_e'(bus.mode);
    eff_enc_s  = msg_active_r ? enc_r : bus.encrypt;

    case (eff_mode_s)
      MODE_CBC: din_next_s = eff_enc_s ? (bus.in_data ^ chain_r) : bus.in_data;
      MODE_CTR: din_next_s = chain_r;
      default:  din_next_s = bus.in_data;
    endcase

    case (eff_mode_s)
      MODE_CTR: enc_next_s = 1'b1;
      default:  enc_next_s = eff_enc_s;
    endcase
  end

  // Output block and next chain value for the block currently in flight.
  always_comb begin
    case (mode_r)
      MODE_CBC: result_s = enc_r ? bus.core_dout : (bus.core_dout ^ chain_r);
      MODE_CTR: result_s = data_r ^ bus.core_dout;
      default:  result_s = bus.core_dout;
    endcase

    // Counter field wraps without carrying into the nonce bits above it.
    ctr_next_s                = chain_r;
    ctr_next_s[CTR_W-1:0]     = chain_r[CTR_W-1:0] + CTR_W'(1'b1);

    if (last_r) begin
      chain_next_s = iv_r;
    end else begin
      case (mode_r)
        MODE_CBC: chain_next_s = enc_r ? out_data_r : data_r;
        MODE_CTR: chain_next_s = ctr_next_s;
        default:  chain_next_s = chain_r;
      endcase
    end
  end

  // Controller FSM with all outputs registered.
  always_ff @(posedge Clk or negedge RstN) begin
    if (!RstN) begin
      state_r        <= ST_IDLE;
      mode_r         <= MODE_ECB;
      enc_r          <= 1'b0;
      msg_active_r   <= 1'b0;
      last_r         <= 1'b0;
      data_r         <= '0;
      iv_r           <= '0;
      chain_r        <= '0;
      out_valid_r    <= 1'b0;
      out_last_r     <= 1'b0;
      out_data_r     <= '0;
      core_start_r   <= 1'b0;
      core_encrypt_r <= 1'b0;
      core_din_r     <= '0;
      mode_err_r     <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (bus.iv_load) begin
            iv_r       <= bus.iv;
            chain_r    <= bus.iv;
            mode_err_r <= 1'b0;
          end else if (bus.in_valid) begin
            data_r         <= bus.in_data;
            last_r         <= bus.in_last;
            mode_r         <= eff_mode_s;
            enc_r          <= eff_enc_s;
            msg_active_r   <= 1'b1;
            core_din_r     <= din_next_s;
            core_encrypt_r <= enc_next_s;
            core_start_r   <= 1'b1;
            if (eff_mode_s == MODE_RSVD) begin
              mode_err_r <= 1'b1;
            end
            state_r <= ST_START;
          end
        end
        ST_START: begin
          core_start_r <= 1'b0;
          state_r      <= ST_WAIT;
        end
        ST_WAIT: begin
          if (bus.core_done) begin
            out_data_r  <= result_s;
            out_last_r  <= last_r;
            out_valid_r <= 1'b1;
            state_r     <= ST_OUT;
          end
        end
        ST_OUT: begin
          if (bus.out_ready) begin
            out_valid_r <= 1'b0;
            out_last_r  <= 1'b0;
            chain_r     <= chain_next_s;
            if (last_r) begin
              msg_active_r <= 1'b0;
            end
            state_r <= ST_IDLE;
          end
        end
        default: begin
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_blowfish_mode_ctrl.sv
// Directed bench for blowfish_mode_ctrl with an XOR-key core model answering 4 cycles after start.
module tb_blowfish_mode_ctrl;

  localparam int BW = 128;
  localparam logic [127:0] KEY_C = {16{8'h0F}};
  localparam logic [127:0] K0E_C = {{15{8'h0F}}, 8'h0E};
  localparam logic [127:0] K00_C = {{15{8'h0F}}, 8'h00};

  logic Clk  = 1'b0;
  logic RstN = 1'b0;
  int   checks_cnt = 0;
  int   errors_cnt = 0;
  int   start_cnt  = 0;

  blowfish_mode_ctrl_if #(.BLOCK_W(BW)) bus ();

  blowfish_mode_ctrl #(.BLOCK_W(BW), .CTR_W(4)) dut (
    .Clk  (Clk),
    .RstN (RstN),
    .bus  (bus)
  );

  always #5 Clk = ~Clk;

  // Core model: latch din on start, raise done for one cycle four edges later.
  logic [127:0] din_lat = '0;
  logic p1 = 1'b0, p2 = 1'b0, p3 = 1'b0, p4 = 1'b0;
  always @(posedge Clk) begin
    if (bus.core_start === 1'b1) din_lat <= bus.core_din;
    p1 <= (bus.core_start === 1'b1);
    p2 <= p1;
    p3 <= p2;
    p4 <= p3;
    if (bus.core_start === 1'b1) start_cnt <= start_cnt + 1;
  end
  assign bus.core_done = p4;
  assign bus.core_dout = din_lat ^ KEY_C;

  task automatic check_eq(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks_cnt++;
    if (obs !== exp) begin
      errors_cnt++;
      $display("FAIL %s obs=%h exp=%h", tag, obs, exp);
    end
  endtask

  task automatic load_iv(input logic [127:0] v, input logic try_in);
    int s0;
    @(negedge Clk);
    bus.iv       = v;
    bus.iv_load  = 1'b1;
    bus.in_valid = try_in;
    #1;
    check_eq("iv_in_ready", bus.in_ready, 0);
    s0 = start_cnt;
    @(posedge Clk); #1;
    bus.iv_load  = 1'b0;
    bus.in_valid = 1'b0;
    @(posedge Clk); #1;
    if (try_in) check_eq("iv_no_accept", start_cnt, s0);
  endtask

  task automatic send_block(input logic [1:0] m, input logic enc, input logic [127:0] d,
                            input logic last, output logic [127:0] res, output logic res_last,
                            output int lat, output logic [127:0] din_seen, output logic enc_seen);
    @(negedge Clk);
    bus.mode     = m;
    bus.encrypt  = enc;
    bus.in_data  = d;
    bus.in_last  = last;
    bus.in_valid = 1'b1;
    @(posedge Clk); #1;
    bus.in_valid = 1'b0;
    din_seen = bus.core_din;
    enc_seen = bus.core_encrypt;
    lat = 0;
    for (int n = 1; n <= 30; n++) begin
      @(posedge Clk); #1;
      if (bus.out_valid) begin
        lat = n;
        break;
      end
    end
    res      = bus.out_data;
    res_last = bus.out_last;
  endtask

  task automatic run(input string tag, input logic [1:0] m, input logic enc, input logic [127:0] d,
                     input logic last, input logic [127:0] exp_out, input logic [127:0] exp_din,
                     input logic exp_enc);
    logic [127:0] res, din_seen;
    logic         res_last, enc_seen;
    int           lat;
    send_block(m, enc, d, last, res, res_last, lat, din_seen, enc_seen);
    check_eq({tag, "_lat"}, lat, 5);
    check_eq({tag, "_din"}, din_seen, exp_din);
    check_eq({tag, "_cenc"}, enc_seen, exp_enc);
    check_eq({tag, "_out"}, res, exp_out);
    check_eq({tag, "_last"}, res_last, last);
    @(posedge Clk); #1;
    check_eq({tag, "_vld_clr"}, bus.out_valid, 0);
  endtask

  initial begin : main
    logic [127:0] res, din_seen;
    logic         res_last, enc_seen, seen_vld;
    int           lat, s0;

    bus.mode = 2'b00; bus.encrypt = 1'b0; bus.iv_load = 1'b0; bus.iv = '0;
    bus.in_valid = 1'b0; bus.in_last = 1'b0; bus.in_data = '0; bus.out_ready = 1'b1;

    #12;
    check_eq("rst_out_valid", bus.out_valid, 0);
    check_eq("rst_out_last", bus.out_last, 0);
    check_eq("rst_out_data", bus.out_data, 0);
    check_eq("rst_core_start", bus.core_start, 0);
    check_eq("rst_core_enc", bus.core_encrypt, 0);
    check_eq("rst_core_din", bus.core_din, 0);
    check_eq("rst_mode_err", bus.mode_err, 0);
    @(negedge Clk); RstN = 1'b1;
    @(posedge Clk); #1;
    check_eq("rst_in_ready", bus.in_ready, 1);

    load_iv(128'h1, 1'b1);

    run("ecb", 2'b00, 1'b1, 128'h1234_56ab_cd13_2536_1234_56ab_cd13_2536, 1'b1,
        128'h1d3b_59a4_c21c_2a39_1d3b_59a4_c21c_2a39,
        128'h1234_56ab_cd13_2536_1234_56ab_cd13_2536, 1'b1);

    run("cbce0", 2'b01, 1'b1, 128'h0, 1'b0, K0E_C, 128'h1, 1'b1);
    run("cbce1", 2'b01, 1'b1, 128'h0, 1'b1, 128'h1, K0E_C, 1'b1);
    run("cbcd0", 2'b01, 1'b0, K0E_C, 1'b0, 128'h0, K0E_C, 1'b0);
    run("cbcd1", 2'b01, 1'b0, 128'h1, 1'b1, 128'h0, 128'h1, 1'b0);

    // Backpressure: result must hold and no second block may start.
    bus.out_ready = 1'b0;
    s0 = start_cnt;
    send_block(2'b00, 1'b1, {16{8'hF0}}, 1'b1, res, res_last, lat, din_seen, enc_seen);
    check_eq("bp_out", res, {16{8'hFF}});
    bus.in_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(posedge Clk); #1;
      check_eq("bp_hold_data", bus.out_data, {16{8'hFF}});
      check_eq("bp_hold_vld", bus.out_valid, 1);
      check_eq("bp_in_ready", bus.in_ready, 0);
    end
    check_eq("bp_starts", start_cnt, s0 + 1);
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    @(posedge Clk); #1;
    check_eq("bp_release", bus.out_valid, 0);

    run("rsvd", 2'b11, 1'b1, 128'h0, 1'b1, KEY_C, 128'h0, 1'b1);
    check_eq("rsvd_err_set", bus.mode_err, 1);
    @(posedge Clk); #1;
    check_eq("rsvd_err_sticky", bus.mode_err, 1);
    load_iv(128'h1, 1'b0);
    check_eq("rsvd_err_clr", bus.mode_err, 0);

    load_iv(128'hF, 1'b0);
    run("ctr0", 2'b10, 1'b0, 128'h0, 1'b0, K00_C, 128'hF, 1'b1);
    run("ctr1", 2'b10, 1'b0, 128'h0, 1'b1, KEY_C, 128'h0, 1'b1);

    // Reset while the core is busy; its late done must be ignored.
    @(negedge Clk);
    bus.mode = 2'b00; bus.encrypt = 1'b1; bus.in_data = KEY_C; bus.in_last = 1'b1;
    bus.in_valid = 1'b1;
    @(posedge Clk); #1;
    bus.in_valid = 1'b0;
    @(posedge Clk); #1;
    RstN = 1'b0;
    #1;
    check_eq("mid_rst_vld", bus.out_valid, 0);
    check_eq("mid_rst_data", bus.out_data, 0);
    check_eq("mid_rst_start", bus.core_start, 0);
    check_eq("mid_rst_cenc", bus.core_encrypt, 0);
    check_eq("mid_rst_din", bus.core_din, 0);
    @(negedge Clk); RstN = 1'b1;
    seen_vld = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(posedge Clk); #1;
      if (bus.out_valid) seen_vld = 1'b1;
    end
    check_eq("late_done_ignored", seen_vld, 0);
    run("post_rst_cbc", 2'b01, 1'b1, 128'h0, 1'b1, KEY_C, 128'h0, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks_cnt, errors_cnt);
    $finish;
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog obs=timeout exp=finish");
    $fatal(1, "bench timeout");
  end

endmodule
